// File: rtl/axi_slave_cmd_bridge_if.sv
// AXI4 slave-side bus bundle for axi_slave_cmd_bridge.
// It carries the five AXI channels (AW, W, B, AR, R) and the single-beat
// req/rsp port that faces local storage.
//   slave  : bridge view. AXI inputs and req_ready/rsp_* come in;
//            AXI readies, B/R channels and req_* go out.
//   master : environment view, the mirror image of slave.
// Sideband inputs (lock/cache/prot/qos/region/user) are not carried.
// The bridge ignores those inputs, so they are left out of the bundle.
interface axi_slave_cmd_bridge_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1
);
    localparam int NB = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   s_axi_awid;
    logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
    logic [7:0]                s_axi_awlen;
    logic [2:0]                s_axi_awsize;
    logic [1:0]                s_axi_awburst;
    logic                      s_axi_awvalid;
    logic                      s_axi_awready;

    logic [AXI_DATA_WIDTH-1:0] s_axi_wdata;
    logic [NB-1:0]             s_axi_wstrb;
    logic                      s_axi_wlast;
    logic                      s_axi_wvalid;
    logic                      s_axi_wready;

    logic [AXI_ID_WIDTH-1:0]   s_axi_bid;
    logic [1:0]                s_axi_bresp;
    logic [AXI_USER_WIDTH-1:0] s_axi_buser;
    logic                      s_axi_bvalid;
    logic                      s_axi_bready;

    logic [AXI_ID_WIDTH-1:0]   s_axi_arid;
    logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
    logic [7:0]                s_axi_arlen;
    logic [2:0]                s_axi_arsize;
    logic [1:0]                s_axi_arburst;
    logic                      s_axi_arvalid;
    logic                      s_axi_arready;

    logic [AXI_ID_WIDTH-1:0]   s_axi_rid;
    logic [AXI_DATA_WIDTH-1:0] s_axi_rdata;
    logic [1:0]                s_axi_rresp;
    logic                      s_axi_rlast;
    logic [AXI_USER_WIDTH-1:0] s_axi_ruser;
    logic                      s_axi_rvalid;
    logic                      s_axi_rready;

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [AXI_ADDR_WIDTH-1:0] req_addr;
    logic [AXI_DATA_WIDTH-1:0] req_wdata;
    logic [NB-1:0]             req_wstrb;

    logic                      rsp_valid;
    logic [AXI_DATA_WIDTH-1:0] rsp_rdata;
    logic                      rsp_err;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_buser, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, s_axi_rvalid,
        input  s_axi_rready,
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_buser, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, s_axi_rvalid,
        output s_axi_rready,
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/axi_slave_cmd_bridge.sv
// AXI4 slave bridge. It accepts one AXI4 write or read burst at a time and
// splits it into single-beat requests on a simple req/rsp port. INCR and FIXED
// bursts are supported. WRAP bursts, reserved burst types and oversize beats
// are answered with SLVERR and never reach the req port. Downstream errors are
// also folded into BRESP/RRESP.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    axi_slave_cmd_bridge_if.slave: AXI AW/W/B/AR/R plus req/rsp
module axi_slave_cmd_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi_slave_cmd_bridge_if.slave bus
);
    localparam int NB      = AXI_DATA_WIDTH / 8;
    localparam int NB_LOG2 = $clog2(NB);

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_RSP, WR_B, RD_REQ, RD_RSP, RD_DATA
    } state_t;

    // WRAP (2'b10) and reserved (2'b11) both have burst[1] set.
    function automatic logic is_bad(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (int'(size) > NB_LOG2);
    endfunction

    // Next beat address: FIXED holds the address. INCR aligns the address to
    // the beat size and then steps by one beat. It wraps at 2^ADDR_WIDTH.
    function automatic logic [AXI_ADDR_WIDTH-1:0] beat_next(
        input logic [AXI_ADDR_WIDTH-1:0] a,
        input logic [2:0]                size,
        input logic [1:0]                burst
    );
        logic [AXI_ADDR_WIDTH-1:0] step;
        step = AXI_ADDR_WIDTH'(1) << size;
        if (burst == 2'b00) return a;
        return (a & ~(step - AXI_ADDR_WIDTH'(1))) + step;
    endfunction

    state_t                    state;
    logic                      prefer_write;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q, cnt_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic                      err_q, bad_q;
    logic                      rd_req_q, req_write_q;
    logic                      bvalid_q, rvalid_q, rlast_q;
    logic [1:0]                bresp_q, rresp_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    logic aw_grant, ar_grant, wr_data, w_hs, last_beat, err_rsp;

    assign aw_grant  = (state == IDLE) && bus.s_axi_awvalid && (!bus.s_axi_arvalid || prefer_write);
    assign ar_grant  = (state == IDLE) && bus.s_axi_arvalid && (!bus.s_axi_awvalid || !prefer_write);
    assign wr_data   = (state == WR_DATA);
    assign w_hs      = bus.s_axi_wvalid && bus.s_axi_wready;
    assign last_beat = (cnt_q == len_q);
    assign err_rsp   = err_q | bus.rsp_err;

    assign bus.s_axi_awready = aw_grant;
    assign bus.s_axi_arready = ar_grant;
    // The W channel passes straight through to the req port. A bad burst
    // drains its W beats locally, so those beats never reach storage.
    assign bus.s_axi_wready  = wr_data && (bad_q || bus.req_ready);
    assign bus.req_valid     = (wr_data && !bad_q && bus.s_axi_wvalid) || rd_req_q;
    assign bus.req_write     = req_write_q;
    assign bus.req_addr      = addr_q;
    assign bus.req_wdata     = wr_data ? bus.s_axi_wdata : '0;
    assign bus.req_wstrb     = wr_data ? bus.s_axi_wstrb : '0;

    assign bus.s_axi_bid     = id_q;
    assign bus.s_axi_bresp   = bresp_q;
    assign bus.s_axi_buser   = {AXI_USER_WIDTH{1'b0}};
    assign bus.s_axi_bvalid  = bvalid_q;
    assign bus.s_axi_rid     = id_q;
    assign bus.s_axi_rdata   = rdata_q;
    assign bus.s_axi_rresp   = rresp_q;
    assign bus.s_axi_rlast   = rlast_q;
    assign bus.s_axi_ruser   = {AXI_USER_WIDTH{1'b0}};
    assign bus.s_axi_rvalid  = rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prefer_write <= 1'b1;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            err_q        <= 1'b0;
            bad_q        <= 1'b0;
            rd_req_q     <= 1'b0;
            req_write_q  <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= '0;
            rvalid_q     <= 1'b0;
            rresp_q      <= '0;
            rlast_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_grant) begin
                        id_q         <= bus.s_axi_awid;
                        addr_q       <= bus.s_axi_awaddr;
                        len_q        <= bus.s_axi_awlen;
                        size_q       <= bus.s_axi_awsize;
                        burst_q      <= bus.s_axi_awburst;
                        bad_q        <= is_bad(bus.s_axi_awburst, bus.s_axi_awsize);
                        cnt_q        <= '0;
                        err_q        <= 1'b0;
                        req_write_q  <= 1'b1;
                        prefer_write <= 1'b0;
                        state        <= WR_DATA;
                    end else if (ar_grant) begin
                        id_q         <= bus.s_axi_arid;
                        addr_q       <= bus.s_axi_araddr;
                        len_q        <= bus.s_axi_arlen;
                        size_q       <= bus.s_axi_arsize;
                        burst_q      <= bus.s_axi_arburst;
                        bad_q        <= is_bad(bus.s_axi_arburst, bus.s_axi_arsize);
                        cnt_q        <= '0;
                        err_q        <= 1'b0;
                        req_write_q  <= 1'b0;
                        rd_req_q     <= !is_bad(bus.s_axi_arburst, bus.s_axi_arsize);
                        prefer_write <= 1'b1;
                        state        <= RD_REQ;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        // A wlast on the wrong beat marks the burst as failed.
                        err_q <= err_q | (bus.s_axi_wlast != last_beat);
                        if (!bad_q) begin
                            state <= WR_RSP;
                        end else if (last_beat) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= 2'b10;
                            state    <= WR_B;
                        end else begin
                            cnt_q  <= cnt_q + 8'd1;
                            addr_q <= beat_next(addr_q, size_q, burst_q);
                        end
                    end
                end
                WR_RSP: begin
                    if (bus.rsp_valid) begin
                        err_q <= err_rsp;
                        if (last_beat) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= err_rsp ? 2'b10 : 2'b00;
                            state    <= WR_B;
                        end else begin
                            cnt_q  <= cnt_q + 8'd1;
                            addr_q <= beat_next(addr_q, size_q, burst_q);
                            state  <= WR_DATA;
                        end
                    end
                end
                WR_B: begin
                    if (bus.s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (bad_q) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= '0;
                        rresp_q  <= 2'b10;
                        rlast_q  <= last_beat;
                        state    <= RD_DATA;
                    end else if (bus.req_ready) begin
                        rd_req_q <= 1'b0;
                        state    <= RD_RSP;
                    end
                end
                RD_RSP: begin
                    if (bus.rsp_valid) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= bus.rsp_rdata;
                        rresp_q  <= bus.rsp_err ? 2'b10 : 2'b00;
                        rlast_q  <= last_beat;
                        state    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.s_axi_rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            state <= IDLE;
                        end else begin
                            cnt_q    <= cnt_q + 8'd1;
                            addr_q   <= beat_next(addr_q, size_q, burst_q);
                            rd_req_q <= !bad_q;
                            state    <= RD_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_cmd_bridge.sv
// Directed bench for axi_slave_cmd_bridge. Inputs change on the falling edge,
// and outputs are sampled shortly after it. A storage model answers each req
// handshake one cycle later, and a monitor logs req, R and B beats.
module tb_axi_slave_cmd_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_slave_cmd_bridge_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) bus ();

    axi_slave_cmd_bridge #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // storage model controls (written by main, read by responder)
    logic [31:0] rd_base  = '0;
    int          idx0     = 0;
    int          err_beat = 255;
    bit          rsp_hold = 1'b0;
    int          n_rsp    = 0;

    logic [31:0] q_addr[$], q_wdata[$], q_rdata[$];
    logic        q_wr[$], q_rlast[$];
    logic [3:0]  q_wstrb[$], q_rid[$], q_bid[$];
    logic [1:0]  q_rresp[$], q_bresp[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Storage responder and bus monitor.
    initial begin : responder
        bit due;
        due = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (due && !rsp_hold) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = rd_base + 32'(n_rsp - idx0);
                bus.rsp_err   = ((n_rsp - idx0) == err_beat);
                n_rsp++;
            end else begin
                bus.rsp_valid = 1'b0;
                bus.rsp_err   = 1'b0;
            end
            due = 1'b0;
            if (bus.req_valid && bus.req_ready) begin
                q_addr.push_back(bus.req_addr);
                q_wr.push_back(bus.req_write);
                q_wdata.push_back(bus.req_wdata);
                q_wstrb.push_back(bus.req_wstrb);
                due = 1'b1;
            end
            if (bus.s_axi_rvalid && bus.s_axi_rready) begin
                q_rdata.push_back(bus.s_axi_rdata);
                q_rresp.push_back(bus.s_axi_rresp);
                q_rlast.push_back(bus.s_axi_rlast);
                q_rid.push_back(bus.s_axi_rid);
            end
            if (bus.s_axi_bvalid && bus.s_axi_bready) begin
                q_bresp.push_back(bus.s_axi_bresp);
                q_bid.push_back(bus.s_axi_bid);
            end
        end
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.s_axi_awready;
            1:       return bus.s_axi_arready;
            2:       return bus.s_axi_wready;
            3:       return bus.s_axi_bvalid;
            default: return bus.s_axi_rvalid;
        endcase
    endfunction

    // Called at a falling edge; returns 1 time unit after the edge where sig is high.
    task automatic wait_for(input int which, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (sig(which)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        bus.s_axi_awid = id; bus.s_axi_awaddr = a; bus.s_axi_awlen = len;
        bus.s_axi_awsize = 3'd2; bus.s_axi_awburst = burst; bus.s_axi_awvalid = 1'b1;
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        bus.s_axi_arid = id; bus.s_axi_araddr = a; bus.s_axi_arlen = len;
        bus.s_axi_arsize = 3'd2; bus.s_axi_arburst = burst; bus.s_axi_arvalid = 1'b1;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        set_aw(id, a, len, burst);
        wait_for(0, "aw");
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        set_ar(id, a, len, burst);
        wait_for(1, "ar");
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic last);
        bus.s_axi_wdata = d; bus.s_axi_wstrb = 4'hF; bus.s_axi_wlast = last; bus.s_axi_wvalid = 1'b1;
        wait_for(2, "w");
        @(negedge clk);
        bus.s_axi_wvalid = 1'b0;
    endtask

    task automatic get_b();
        wait_for(3, "b");
        bus.s_axi_bready = 1'b1;
        @(negedge clk);
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic get_r(input bit stall);
        logic [31:0] snap;
        wait_for(4, "r");
        if (stall) begin
            snap = bus.s_axi_rdata;
            repeat (3) begin
                @(negedge clk);
                #1;
                chk("t4_stall_rdata", bus.s_axi_rdata, snap);
                chk("t4_stall_rvalid", 32'(bus.s_axi_rvalid), 32'd1);
                chk("t4_stall_rlast", 32'(bus.s_axi_rlast), 32'd0);
            end
        end
        bus.s_axi_rready = 1'b1;
        @(negedge clk);
        bus.s_axi_rready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int qb, rb, bb;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0;
        bus.s_axi_awsize = '0; bus.s_axi_awburst = '0;
        bus.s_axi_arvalid = 1'b0; bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
        bus.s_axi_arsize = '0; bus.s_axi_arburst = '0;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0;
        bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0; bus.req_ready = 1'b1;

        // Reset state
        #7;
        chk("rst_awready", 32'(bus.s_axi_awready), 0);
        chk("rst_wready",  32'(bus.s_axi_wready), 0);
        chk("rst_bvalid",  32'(bus.s_axi_bvalid), 0);
        chk("rst_rvalid",  32'(bus.s_axi_rvalid), 0);
        chk("rst_reqvalid", 32'(bus.req_valid), 0);
        chk("rst_reqaddr", bus.req_addr, 0);
        chk("rst_rdata",   bus.s_axi_rdata, 0);
        chk("rst_bresp",   32'(bus.s_axi_bresp), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single-beat write
        qb = q_addr.size(); bb = q_bresp.size(); idx0 = n_rsp; err_beat = 255;
        send_aw(4'd3, 32'h10, 8'd0, 2'b01);
        send_w(32'hABCD1234, 1'b1);
        get_b();
        chk("t1_nreq",  32'(q_addr.size() - qb), 1);
        chk("t1_addr",  q_addr[qb], 32'h10);
        chk("t1_write", 32'(q_wr[qb]), 1);
        chk("t1_wdata", q_wdata[qb], 32'hABCD1234);
        chk("t1_wstrb", 32'(q_wstrb[qb]), 32'hF);
        chk("t1_bid",   32'(q_bid[bb]), 3);
        chk("t1_bresp", 32'(q_bresp[bb]), 0);

        // 2: single-beat read
        qb = q_addr.size(); rb = q_rdata.size(); idx0 = n_rsp; rd_base = 32'hABCD1234;
        send_ar(4'd5, 32'h10, 8'd0, 2'b01);
        get_r(1'b0);
        chk("t2_addr",  q_addr[qb], 32'h10);
        chk("t2_write", 32'(q_wr[qb]), 0);
        chk("t2_wstrb", 32'(q_wstrb[qb]), 0);
        chk("t2_rdata", q_rdata[rb], 32'hABCD1234);
        chk("t2_rid",   32'(q_rid[rb]), 5);
        chk("t2_rresp", 32'(q_rresp[rb]), 0);
        chk("t2_rlast", 32'(q_rlast[rb]), 1);
        #1;
        chk("t2_idle",  32'(dut.state), 0);
        @(negedge clk);

        // 3: INCR write len3, downstream error on beat 1
        qb = q_addr.size(); bb = q_bresp.size(); idx0 = n_rsp; err_beat = 1;
        send_aw(4'd0, 32'h20, 8'd3, 2'b01);
        send_w(32'h11111111, 1'b0);
        send_w(32'h22222222, 1'b0);
        send_w(32'h33333333, 1'b0);
        send_w(32'h44444444, 1'b1);
        get_b();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_addr%0d", i), q_addr[qb+i], 32'h20 + 32'(4*i));
            chk($sformatf("t3_wdata%0d", i), q_wdata[qb+i], 32'h11111111 * 32'(i+1));
        end
        chk("t3_nb",    32'(q_bresp.size() - bb), 1);
        chk("t3_bresp", 32'(q_bresp[bb]), 2);
        err_beat = 255;

        // 4: FIXED read len3, rready stalled on beat 2
        qb = q_addr.size(); rb = q_rdata.size(); idx0 = n_rsp; rd_base = 32'h50000000;
        send_ar(4'd7, 32'h40, 8'd3, 2'b00);
        for (int i = 0; i < 4; i++) get_r(i == 2);
        chk("t4_nreq", 32'(q_addr.size() - qb), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_addr%0d", i), q_addr[qb+i], 32'h40);
            chk($sformatf("t4_rdata%0d", i), q_rdata[rb+i], 32'h50000000 + 32'(i));
            chk($sformatf("t4_rlast%0d", i), 32'(q_rlast[rb+i]), (i == 3) ? 1 : 0);
            chk($sformatf("t4_rid%0d", i), 32'(q_rid[rb+i]), 7);
        end

        // 5: arbitration after reset: write first, then read wins the next contention
        do_reset();
        qb = q_addr.size(); idx0 = n_rsp;
        set_aw(4'd1, 32'h200, 8'd0, 2'b01);
        set_ar(4'd2, 32'h300, 8'd0, 2'b01);
        #1;
        chk("t5_aw_first", 32'(bus.s_axi_awready), 1);
        chk("t5_ar_waits", 32'(bus.s_axi_arready), 0);
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
        send_w(32'h00000055, 1'b1);
        set_aw(4'd3, 32'h210, 8'd0, 2'b01);
        get_b();
        #1;
        chk("t5_ar_second", 32'(bus.s_axi_arready), 1);
        chk("t5_aw_waits",  32'(bus.s_axi_awready), 0);
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        get_r(1'b0);
        wait_for(0, "aw5");
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
        send_w(32'h00000066, 1'b1);
        get_b();
        chk("t5_nreq", 32'(q_addr.size() - qb), 3);
        chk("t5_ord0", 32'(q_wr[qb]), 1);
        chk("t5_ord1", 32'(q_wr[qb+1]), 0);
        chk("t5_ord2", 32'(q_wr[qb+2]), 1);
        chk("t5_addr1", q_addr[qb+1], 32'h300);
        chk("t5_addr2", q_addr[qb+2], 32'h210);

        // 6: WRAP read is rejected without touching storage
        qb = q_addr.size(); rb = q_rdata.size();
        send_ar(4'd9, 32'h80, 8'd1, 2'b10);
        get_r(1'b0);
        get_r(1'b0);
        chk("t6_noreq", 32'(q_addr.size() - qb), 0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t6_rdata%0d", i), q_rdata[rb+i], 0);
            chk($sformatf("t6_rresp%0d", i), 32'(q_rresp[rb+i]), 2);
            chk($sformatf("t6_rlast%0d", i), 32'(q_rlast[rb+i]), (i == 1) ? 1 : 0);
        end

        // 6b: reset while waiting for a read response
        rsp_hold = 1'b1;
        send_ar(4'd2, 32'h100, 8'd0, 2'b01);
        @(negedge clk);
        #1;
        chk("t6_in_rd_rsp", 32'(dut.state), 5);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_reqvalid", 32'(bus.req_valid), 0);
        chk("t6_rst_rvalid",   32'(bus.s_axi_rvalid), 0);
        chk("t6_rst_bvalid",   32'(bus.s_axi_bvalid), 0);
        chk("t6_rst_idle",     32'(dut.state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_hold = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
